// File: rtl/rf_multiport.sv
// Multi-port register file with write-to-read bypass, optional hardwired zero entry,
// debug read port and a one-entry-per-cycle bulk-clear engine.
module rf_multiport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  input  logic [AW-1:0]     dbg_sel,
  output logic [DW-1:0]     dbg_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_drop
);

  // state | meaning
  // IDLE  | normal read/write operation, bypass active
  // CLEAR | zeroing one entry per cycle, writes dropped, bypass off
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] CNT_START = (AW+1)'(ZERO_REG != 0 ? 1 : 0);
  localparam logic [AW:0] CNT_LAST  = (AW+1)'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic          wr0_ok, wr1_ok;

  // Writes to the hardwired zero entry are not real writes: never stored, never dropped.
  assign wr0_ok = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign wr1_ok = we1 && !(ZERO_REG != 0 && wa1 == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = CNT_START;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_drop <= (state == CLEAR) && (wr0_ok || wr1_ok);
    end
  end

  assign clr_busy = (state == CLEAR);

  // Port 1 is assigned last so it wins on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt[AW-1:0]] <= '0;
    end else begin
      if (wr0_ok) mem[wa0] <= wd0;
      if (wr1_ok) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] val;

    assign addr = ra[k*AW +: AW];

    always_comb begin
      val = mem[addr];
      if (ZERO_REG != 0 && addr == '0) begin
        val = '0;
      end else if (BYPASS != 0 && state == IDLE) begin
        if (wr1_ok && wa1 == addr)      val = wd1;
        else if (wr0_ok && wa0 == addr) val = wd0;
      end
    end

    assign rd[k*DW +: DW] = val;
  end

  assign dbg_data = (ZERO_REG != 0 && dbg_sel == '0) ? '0 : mem[dbg_sel];

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: randomized and directed stimulus checked against an
// array-based model of the register file and its clear sequence.
module tb_rf_multiport;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              we0, we1, clr_req;
  logic [AW-1:0]     wa0, wa1, dbg_sel;
  logic [DW-1:0]     wd0, wd1, dbg_data;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic              clr_busy, wr_drop;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  int            m_ptr;
  bit            m_drop;

  rf_multiport #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 0;
    m_ptr  = 0;
    m_drop = 0;
  endtask

  // Expected read value from the model given the inputs currently applied.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (!m_busy && we1 && wa1 == a) return wd1;
    if (!m_busy && we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  task automatic idle_inputs();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    clr_req = 0; ra = '0; dbg_sel = '0;
  endtask

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (!m_busy) begin
      m_drop = 0;
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
      if (clr_req) begin
        m_busy = 1;
        m_ptr  = 1;
      end
    end else begin
      m_drop = (we0 && wa0 != 0) || (we1 && wa1 != 0);
      m_mem[m_ptr] = '0;
      m_ptr++;
      if (m_ptr == DEPTH) m_busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      ra[0 +: AW]  = AW'(a);
      ra[AW +: AW] = AW'(DEPTH - 1 - a);
      dbg_sel      = AW'(a);
      #1;
      for (int k = 0; k < NRD; k++) begin
        n_tests++;
        if (rd[k*DW +: DW] !== '0) begin
          n_fail++;
          $display("FAIL reset_rd%0d addr=%0d got=%h exp=0", k, ra[k*AW +: AW], rd[k*DW +: DW]);
        end
      end
      n_tests++;
      if (dbg_data !== '0) begin
        n_fail++;
        $display("FAIL reset_dbg addr=%0d got=%h exp=0", a, dbg_data);
      end
    end
    n_tests++;
    if (clr_busy !== 1'b0 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b drop=%b exp busy=0 drop=0", clr_busy, wr_drop);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    idle_inputs();
    we0 = 1; wa0 = 5; wd0 = 32'h1234_5678; ra[0 +: AW] = 5;
    #1;
    n_tests++;
    if (rd[0 +: DW] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL bypass_rd0 got=%h exp=12345678", rd[0 +: DW]);
    end
    n_tests++;
    if (dbg_data !== m_mem[0]) begin
      n_fail++;
      $display("FAIL dbg_no_bypass got=%h exp=%h", dbg_data, m_mem[0]);
    end
    dbg_sel = 5;
    #1;
    n_tests++;
    if (dbg_data !== 32'h0) begin
      n_fail++;
      $display("FAIL dbg_before_write got=%h exp=0", dbg_data);
    end
    tick();
    idle_inputs();
    dbg_sel = 5;
    #1;
    n_tests++;
    if (dbg_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL dbg_after_write got=%h exp=12345678", dbg_data);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    we0 = 1; wa0 = 7; wd0 = 32'hAAAA_AAAA;
    we1 = 1; wa1 = 7; wd1 = 32'h5555_5555;
    ra[0 +: AW] = 7; ra[AW +: AW] = 7;
    #1;
    for (int k = 0; k < NRD; k++) begin
      n_tests++;
      if (rd[k*DW +: DW] !== 32'h5555_5555) begin
        n_fail++;
        $display("FAIL collide_bypass_rd%0d got=%h exp=55555555", k, rd[k*DW +: DW]);
      end
    end
    tick();
    idle_inputs();
    dbg_sel = 7;
    #1;
    n_tests++;
    if (dbg_data !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL collide_stored got=%h exp=55555555", dbg_data);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF;
    we0 = 1; wa0 = 0; wd0 = 32'hCAFE_F00D;
    #1;
    n_tests++;
    if (rd[0 +: DW] !== '0) begin
      n_fail++;
      $display("FAIL zero_bypass got=%h exp=0", rd[0 +: DW]);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (rd[0 +: DW] !== '0 || dbg_data !== '0) begin
      n_fail++;
      $display("FAIL zero_stored got rd=%h dbg=%h exp=0", rd[0 +: DW], dbg_data);
    end
    n_tests++;
    if (wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_drop got=%b exp=0", wr_drop);
    end
  endtask

  task automatic test_random_rw(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      idle_inputs();
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      for (int k = 0; k < NRD; k++)
        ra[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? (k == 0 ? wa0 : wa1) : AW'($urandom);
      dbg_sel = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom);
      #1;
      for (int k = 0; k < NRD; k++) begin
        n_tests++;
        if (rd[k*DW +: DW] !== exp_rd(ra[k*AW +: AW])) begin
          n_fail++;
          $display("FAIL rand_rd%0d cyc=%0d addr=%0d got=%h exp=%h", k, c,
                   ra[k*AW +: AW], rd[k*DW +: DW], exp_rd(ra[k*AW +: AW]));
        end
      end
      n_tests++;
      if (dbg_data !== m_mem[dbg_sel]) begin
        n_fail++;
        $display("FAIL rand_dbg cyc=%0d addr=%0d got=%h exp=%h", c, dbg_sel, dbg_data, m_mem[dbg_sel]);
      end
      tick();
      n_tests++;
      if (wr_drop !== m_drop || clr_busy !== m_busy) begin
        n_fail++;
        $display("FAIL rand_flags cyc=%0d got drop=%b busy=%b exp drop=%b busy=%b",
                 c, wr_drop, clr_busy, m_drop, m_busy);
      end
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    idle_inputs();
    for (int i = 1; i < DEPTH; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = DW'(i);
      tick();
    end
    idle_inputs();
    clr_req = 1;
    tick();
    idle_inputs();
    busy_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ra[0 +: AW]  = AW'(cyc);
      ra[AW +: AW] = AW'(cyc + 1);
      dbg_sel      = AW'($urandom);
      if (cyc == 4) begin
        we0 = 1; wa0 = 3; wd0 = 32'hDEAD_BEEF;
        ra[0 +: AW] = 3;
      end
      if (cyc == 8) clr_req = 1;
      #1;
      if (clr_busy) busy_cnt++;
      n_tests++;
      if (clr_busy !== m_busy) begin
        n_fail++;
        $display("FAIL clr_busy cyc=%0d got=%b exp=%b", cyc, clr_busy, m_busy);
      end
      for (int k = 0; k < NRD; k++) begin
        n_tests++;
        if (rd[k*DW +: DW] !== exp_rd(ra[k*AW +: AW])) begin
          n_fail++;
          $display("FAIL clr_rd%0d cyc=%0d addr=%0d got=%h exp=%h", k, cyc,
                   ra[k*AW +: AW], rd[k*DW +: DW], exp_rd(ra[k*AW +: AW]));
        end
      end
      n_tests++;
      if (dbg_data !== m_mem[dbg_sel]) begin
        n_fail++;
        $display("FAIL clr_dbg cyc=%0d addr=%0d got=%h exp=%h", cyc, dbg_sel, dbg_data, m_mem[dbg_sel]);
      end
      tick();
      idle_inputs();
      n_tests++;
      if (wr_drop !== m_drop) begin
        n_fail++;
        $display("FAIL clr_drop cyc=%0d got=%b exp=%b", cyc, wr_drop, m_drop);
      end
    end
    n_tests++;
    if (busy_cnt != DEPTH - 1) begin
      n_fail++;
      $display("FAIL clr_duration got=%0d exp=%0d", busy_cnt, DEPTH - 1);
    end
    for (int a = 0; a < DEPTH; a++) begin
      dbg_sel = AW'(a);
      #1;
      n_tests++;
      if (dbg_data !== '0) begin
        n_fail++;
        $display("FAIL clr_final addr=%0d got=%h exp=0", a, dbg_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] val;
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      we0 = 1; wa0 = AW'($urandom_range(1, DEPTH - 1)); wd0 = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
    clr_req = 1;
    tick();
    idle_inputs();
    for (int c = 0; c < 10; c++) tick();
    n_tests++;
    if (clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midclr_busy_before got=%b exp=1", clr_busy);
    end
    rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_busy_after got=%b exp=0", clr_busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      dbg_sel = AW'(a);
      ra[0 +: AW] = AW'(a);
      ra[AW +: AW] = AW'(a);
      #1;
      n_tests++;
      if (dbg_data !== '0 || rd !== '0) begin
        n_fail++;
        $display("FAIL midclr_zero addr=%0d got dbg=%h rd=%h exp=0", a, dbg_data, rd);
      end
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    idle_inputs();
    val = $urandom;
    we0 = 1; wa0 = 9; wd0 = val; ra[0 +: AW] = 9;
    #1;
    n_tests++;
    if (rd[0 +: DW] !== val) begin
      n_fail++;
      $display("FAIL postrst_bypass got=%h exp=%h", rd[0 +: DW], val);
    end
    tick();
    idle_inputs();
    dbg_sel = 9;
    #1;
    n_tests++;
    if (dbg_data !== val || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL postrst_write got dbg=%h drop=%b exp dbg=%h drop=0", dbg_data, wr_drop, val);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_random_rw(300);
    test_clear();
    test_random_rw(100);
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
